wb_stage: RTL

//   Write-back stage of the 16-bit 5-stage pipeline. Holds the MEM/WB pipeline register.

---
 rtl/wb_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back source select,
// register-file write port, forwarding mirror, HALT retirement tracking
// and a retired-instruction counter.
module wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_pcinc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [1:0]        in_wbsel,
  input  logic              in_regwrite,
  input  logic [REG_W-1:0]  in_dest,
  input  logic              in_halt,
  output logic [REG_W-1:0]  writeregsel,
  output logic [DATA_W-1:0] writedata,
  output logic              write,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              halted,
  output logic [CNT_W-1:0]  ret_count,
  output logic              err
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   mem_q, mem_d;
  logic [DATA_W-1:0]   pcinc_q, pcinc_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [1:0]          wbsel_q, wbsel_d;
  logic                regwrite_q, regwrite_d;
  logic [REG_W-1:0]    dest_q, dest_d;
  logic                halt_q, halt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                halt_retire;
  logic                accept;

  // A HALT sitting in the register retires this cycle; it closes the stage.
  assign halt_retire = valid_q & halt_q;

  // FSM next state and handshake outputs; capture decision for the register.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = 1'b1;
        if (halt_retire) state_d = ST_HALT;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    // flush wins over in_valid; the HALT edge also clears the stage.
    accept     = in_valid & in_ready & ~flush;
    valid_d    = accept & ~halt_retire;
    alu_d      = alu_q;
    mem_d      = mem_q;
    pcinc_d    = pcinc_q;
    imm_d      = imm_q;
    wbsel_d    = wbsel_q;
    regwrite_d = regwrite_q;
    dest_d     = dest_q;
    halt_d     = halt_q;
    if (valid_d) begin
      alu_d      = in_alu;
      mem_d      = in_mem;
      pcinc_d    = in_pcinc;
      imm_d      = in_imm;
      wbsel_d    = in_wbsel;
      regwrite_d = in_regwrite;
      dest_d     = in_dest;
      halt_d     = in_halt;
    end

    // Every valid entry retires, including HALT and illegal-select entries.
    cnt_d = cnt_q + CNT_W'(valid_q);
  end

  // State, pipeline register and retirement counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      valid_q    <= 1'b0;
      alu_q      <= '0;
      mem_q      <= '0;
      pcinc_q    <= '0;
      imm_q      <= '0;
      wbsel_q    <= 2'b00;
      regwrite_q <= 1'b0;
      dest_q     <= '0;
      halt_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      alu_q      <= alu_d;
      mem_q      <= mem_d;
      pcinc_q    <= pcinc_d;
      imm_q      <= imm_d;
      wbsel_q    <= wbsel_d;
      regwrite_q <= regwrite_d;
      dest_q     <= dest_d;
      halt_q     <= halt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Write-back source select and rf write port, purely from the register.
  always_comb begin
    writedata = alu_q;
    err       = 1'b0;
    case (wbsel_q)
      2'b00: writedata = alu_q;
      2'b01: writedata = mem_q;
      2'b10: writedata = pcinc_q;
      default: begin
        writedata = imm_q;
        err       = valid_q;
      end
    endcase
    writeregsel = dest_q;
    write       = valid_q & regwrite_q & ~halt_q & (wbsel_q != 2'b11);
    fwd_valid   = write;
    fwd_reg     = writeregsel;
    fwd_data    = writedata;
  end

  assign ret_count = cnt_q;

endmodule
